// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard / stall / flush controller for an in-order pipeline of
//               STAGES pipeline registers. It arbitrates between halt, memory
//               wait, branch redirect, load-use and fetch-miss conditions.
//               It also tracks per-register valid bits, the RUN/DRAIN/HALTED
//               state machine, a saturating memory-wait watchdog and a stall
//               cycle counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : STAGES     - number of pipeline registers (3..8)
//               MEM_REG    - register index holding the memory-stage instr
//               WAIT_LIMIT - consecutive wait cycles that raise mem_timeout
// Ports       : CLK          in   clock, rising edge
//               nRST         in   asynchronous reset, active high
//               ihit         in   instruction fetch hit
//               dhit         in   data access complete
//               mem_req      in   instr in reg MEM_REG is a load/store
//               load_use     in   decode depends on a load still in reg 1
//               redirect     in   taken branch/jump resolved at reg MEM_REG
//               halt_dec     in   instr in reg 0 is HALT
//               halt_wb      in   instr in reg STAGES-1 is HALT
//               pc_en        out  PC may load its next value
//               stage_en     out  per-register load enable
//               stage_flush  out  per-register bubble insert
//               valid        out  per-register real-instruction flag
//               halt         out  processor halted (sticky)
//               state        out  RUN=0, DRAIN=1, HALTED=2
//               mem_timeout  out  memory wait reached WAIT_LIMIT (sticky)
//               stall_cycles out  cycles in RUN/DRAIN with pc_en=0
// ============================================================================
module pipeline_ctrl #(
  parameter int STAGES     = 4,
  parameter int MEM_REG    = 2,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_req,
  input  logic              load_use,
  input  logic              redirect,
  input  logic              halt_dec,
  input  logic              halt_wb,
  output logic              pc_en,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_flush,
  output logic [STAGES-1:0] valid,
  output logic              halt,
  output logic [1:0]        state,
  output logic              mem_timeout,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [STAGES-1:0] C_ALL          = '1;
  localparam logic [STAGES-1:0] C_REG0         = STAGES'(1);
  localparam logic [STAGES-1:0] C_REG1         = STAGES'(2);
  // Redirect squashes everything younger than the resolving instruction,
  // i.e. registers 0..MEM_REG.
  localparam logic [STAGES-1:0] C_REDIR_FLUSH  = STAGES'((1 << (MEM_REG + 1)) - 1);
  localparam logic [15:0]       C_WAIT_LIMIT   = 16'(WAIT_LIMIT);

  state_t             state_q;
  logic               halt_q;
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_d;
  logic [15:0]        wait_cnt_q;
  logic [15:0]        wait_cnt_d;
  logic               timeout_q;
  logic               timeout_d;
  logic [31:0]        stall_q;
  logic [31:0]        stall_d;

  logic               mem_wait;
  logic               halt_retire;

  assign mem_wait    = valid_q[MEM_REG] & mem_req & ~dhit;
  // A HALT reaching the last register retires unless memory is still busy.
  assign halt_retire = halt_wb & valid_q[STAGES-1] & ~mem_wait;

  // --------------------------------------------------------------------------
  // Stall / flush arbitration, highest priority first. While reset is held
  // the outputs present the free-running (normal) pattern.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_en       = 1'b1;
    stage_en    = C_ALL;
    stage_flush = '0;
    if (!nRST) begin
      if (state_q == ST_HALTED || mem_wait) begin
        pc_en    = 1'b0;
        stage_en = '0;
      end else if (redirect) begin
        stage_flush = C_REDIR_FLUSH;
      end else if (load_use) begin
        // Hold decode, push a bubble into reg 1, let older work proceed.
        pc_en       = 1'b0;
        stage_en    = C_ALL & ~C_REG0;
        stage_flush = C_REG1;
      end else if (state_q == ST_DRAIN || !ihit) begin
        pc_en       = 1'b0;
        stage_flush = C_REG0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Valid bit propagation: flush wins over upstream data.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_valid
      if (k == 0) begin : g_head
        assign valid_d[k] = stage_en[k] ? ~stage_flush[k] : valid_q[k];
      end else begin : g_body
        assign valid_d[k] = stage_en[k] ? (~stage_flush[k] & valid_q[k-1])
                                        : valid_q[k];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Wait watchdog and stall counter next-state.
  // --------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == C_WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 16'd1;
    end
    // Timeout becomes visible on the same edge the counter reaches the limit.
    timeout_d = timeout_q | (wait_cnt_d == C_WAIT_LIMIT);
    stall_d   = stall_q;
    if (state_q != ST_HALTED && !pc_en) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered halt flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // An older retiring HALT beats a same-cycle redirect.
          if (halt_retire) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end else if (halt_dec & valid_q[0] & ~redirect & ~mem_wait) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (halt_retire) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end else if (redirect & ~mem_wait) begin
            // The decoded HALT was on the wrong path and has been squashed.
            state_q <= ST_RUN;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      valid_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign valid        = valid_q;
  assign halt         = halt_q;
  assign state        = state_q;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Directed scenarios
//               (fill, memory wait, load-use, redirect, timeout, halt) are
//               followed by randomized stimulus with occasional resets, all
//               checked every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int S  = 4;
  localparam int MR = 2;
  localparam int WL = 4;
  localparam logic [S-1:0] ALL = '1;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         ihit, dhit, mem_req, load_use, redirect, halt_dec, halt_wb;
  logic         pc_en;
  logic [S-1:0] stage_en, stage_flush, valid;
  logic         halt;
  logic [1:0]   state;
  logic         mem_timeout;
  logic [31:0]  stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  pipeline_ctrl #(
    .STAGES    (S),
    .MEM_REG   (MR),
    .WAIT_LIMIT(WL)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_req     (mem_req),
    .load_use    (load_use),
    .redirect    (redirect),
    .halt_dec    (halt_dec),
    .halt_wb     (halt_wb),
    .pc_en       (pc_en),
    .stage_en    (stage_en),
    .stage_flush (stage_flush),
    .valid       (valid),
    .halt        (halt),
    .state       (state),
    .mem_timeout (mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Reference model: architectural state plus the action chosen this cycle.
  // Actions: 0 halted, 1 memory wait, 2 redirect, 3 load-use, 4 bubble, 5 run.
  // --------------------------------------------------------------------------
  logic [S-1:0] m_valid;
  int           m_state;
  int           m_wcnt;
  bit           m_tmo;
  logic [31:0]  m_stall;

  int           e_act;
  bit           e_pc;
  logic [S-1:0] e_en, e_fl;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_mem_wait();
    return m_valid[MR] && mem_req && !dhit;
  endfunction

  task automatic model_reset();
    m_valid = '0;
    m_state = 0;
    m_wcnt  = 0;
    m_tmo   = 0;
    m_stall = '0;
  endtask

  task automatic model_comb();
    if (nRST)                         e_act = 5;
    else if (m_state == 2)            e_act = 0;
    else if (model_mem_wait())        e_act = 1;
    else if (redirect)                e_act = 2;
    else if (load_use)                e_act = 3;
    else if (m_state == 1 || !ihit)   e_act = 4;
    else                              e_act = 5;
    e_pc = (e_act == 2) || (e_act == 5);
    e_en = (e_act <= 1) ? '0 : ALL;
    e_fl = '0;
    case (e_act)
      2: for (int k = 0; k <= MR; k++) e_fl[k] = 1'b1;
      3: begin e_en[0] = 1'b0; e_fl[1] = 1'b1; end
      4: e_fl[0] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_clock();
    bit           mw;
    bit           retire;
    logic [S-1:0] shifted;
    int           ns;
    if (nRST) return;
    mw      = model_mem_wait();
    retire  = halt_wb && m_valid[S-1] && !mw;
    // Every enabled register takes what is upstream of it (reg 0 takes a new
    // instruction), unless it is flushed; disabled registers keep their value.
    shifted = S'({m_valid, 1'b1});
    ns      = m_state;
    if (m_state != 2 && retire)                                         ns = 2;
    else if (m_state == 0 && halt_dec && m_valid[0] && !redirect && !mw) ns = 1;
    else if (m_state == 1 && redirect && !mw)                           ns = 0;
    if (m_state != 2 && !e_pc) m_stall = m_stall + 32'd1;
    if (mw) m_wcnt = (m_wcnt < WL) ? m_wcnt + 1 : WL;
    else    m_wcnt = 0;
    if (m_wcnt == WL) m_tmo = 1;
    m_valid = (shifted & e_en & ~e_fl) | (m_valid & ~e_en);
    m_state = ns;
  endtask

  task automatic check_outputs();
    model_comb();
    check_eq("pc_en",        32'(pc_en),        32'(e_pc));
    check_eq("stage_en",     32'(stage_en),     32'(e_en));
    check_eq("stage_flush",  32'(stage_flush),  32'(e_fl));
    check_eq("valid",        32'(valid),        32'(m_valid));
    check_eq("state",        32'(state),        32'(m_state));
    check_eq("halt",         32'(halt),         32'(m_state == 2));
    check_eq("mem_timeout",  32'(mem_timeout),  32'(m_tmo));
    check_eq("stall_cycles", stall_cycles,      m_stall);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge CLK);
    model_clock();
    @(negedge CLK);
  endtask

  task automatic set_in(input bit ih, input bit dh, input bit mq, input bit lu,
                        input bit rd, input bit hd, input bit hw);
    ihit = ih; dhit = dh; mem_req = mq; load_use = lu;
    redirect = rd; halt_dec = hd; halt_wb = hw;
  endtask

  task automatic do_reset(input int n);
    nRST = 1'b1;
    model_reset();
    repeat (n) cycle();
    nRST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge CLK);

    // Reset state, with a fetch miss present to show the override.
    set_in(0, 0, 0, 0, 1, 0, 0);
    #1;
    check_eq("rst_pc_en", 32'(pc_en), 32'd1);
    check_eq("rst_stage_en", 32'(stage_en), 32'hF);
    check_eq("rst_flush", 32'(stage_flush), 32'h0);
    set_in(1, 0, 0, 0, 0, 0, 0);
    do_reset(2);

    // Pipeline fill.
    repeat (4) cycle();
    check_eq("fill_valid", 32'(valid), 32'hF);
    check_eq("fill_stall", stall_cycles, 32'd0);

    // Memory wait for three cycles, then completion.
    set_in(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("mw_stage_en", 32'(stage_en), 32'h0);
      check_eq("mw_pc_en", 32'(pc_en), 32'd0);
      cycle();
    end
    check_eq("mw_valid", 32'(valid), 32'hF);
    check_eq("mw_stall", stall_cycles, 32'd3);
    set_in(1, 1, 1, 0, 0, 0, 0);
    cycle();
    set_in(1, 0, 0, 0, 0, 0, 0);

    // Load-use bubble.
    set_in(1, 0, 0, 1, 0, 0, 0);
    #1;
    check_eq("lu_stage_en", 32'(stage_en), 32'hE);
    check_eq("lu_flush", 32'(stage_flush), 32'h2);
    cycle();
    check_eq("lu_valid", 32'(valid), 32'hD);
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Redirect.
    set_in(1, 0, 0, 0, 1, 0, 0);
    #1;
    check_eq("rd_flush", 32'(stage_flush), 32'h7);
    check_eq("rd_pc_en", 32'(pc_en), 32'd1);
    cycle();
    check_eq("rd_valid", 32'(valid), 32'h8);
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Timeout after WL consecutive wait cycles; sticky afterwards.
    set_in(1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 3) check_eq("tmo_before", 32'(mem_timeout), 32'd0);
      if (i == 4) check_eq("tmo_rise", 32'(mem_timeout), 32'd1);
    end
    set_in(1, 1, 1, 0, 0, 0, 0);
    repeat (2) cycle();
    check_eq("tmo_sticky", 32'(mem_timeout), 32'd1);

    // HALT decoded, drain, then HALT retires.
    set_in(1, 0, 0, 0, 0, 1, 0);
    cycle();
    check_eq("drain_state", 32'(state), 32'd1);
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    set_in(1, 0, 0, 0, 0, 0, 1);
    cycle();
    check_eq("halt_state", 32'(state), 32'd2);
    check_eq("halt_flag", 32'(halt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check_eq("halted_stage_en", 32'(stage_en), 32'h0);
      cycle();
    end

    // Randomized traffic with occasional resets.
    set_in(1, 0, 0, 0, 0, 0, 0);
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
             $urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) begin
        nRST = 1'b1;
        model_reset();
      end else begin
        nRST = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter STAGES, default 4: number of pipeline registers; reg k latches output of stage k (0=IF/ID ... STAGES-1=MEM/WB); legal range 3..8.
REQ-002 Parameter MEM_REG, default 2: index of the register holding the memory-stage instruction; legal range 1..STAGES-2.
REQ-003 Parameter WAIT_LIMIT, default 255: consecutive memory-wait cycles that raise timeout; legal range 1..65535.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 nRST  in  1  reset; asynchronous and active-high (asserted = 1).
REQ-006 ihit  in  1  instruction fetch hit this cycle.
REQ-007 dhit  in  1  data access complete this cycle.
REQ-008 mem_req  in  1  instruction in reg MEM_REG is a load or store.
REQ-009 load_use  in  1  decode needs the result of a load still in reg 1.
REQ-010 redirect  in  1  branch or jump taken, resolved at the output of reg MEM_REG.
REQ-011 halt_dec  in  1  instruction in reg 0 is HALT.
REQ-012 halt_wb  in  1  instruction in reg STAGES-1 is HALT.
REQ-013 pc_en  out  1  PC may load its next value.
REQ-014 stage_en  out  STAGES  per-register load enable.
REQ-015 stage_flush  out  STAGES  per-register bubble insert; loads a bubble instead of upstream data.
REQ-016 valid  out  STAGES  register k holds a real instruction.
REQ-017 halt  out  1  processor halted, sticky.
REQ-018 state  out  2  FSM state: RUN=0, DRAIN=1, HALTED=2.
REQ-019 mem_timeout  out  1  sticky; memory wait reached WAIT_LIMIT.
REQ-020 stall_cycles  out  32  count of cycles in RUN or DRAIN with pc_en=0.

Function
REQ-021 mem_wait = valid[MEM_REG] & mem_req & ~dhit; all outputs below are combinational from the registered state and the current inputs.
REQ-022 Priority, highest first: HALTED, mem_wait, redirect, load_use, DRAIN fetch block, ~ihit, normal.
REQ-023 HALTED: pc_en=0, stage_en=0, stage_flush=0.
REQ-024 mem_wait: pc_en=0, stage_en=0, stage_flush=0; every register holds.
REQ-025 redirect: pc_en=1, stage_en all 1, stage_flush[k]=1 for k=0..MEM_REG, 0 for the others.
REQ-026 load_use: pc_en=0, stage_en[0]=0, stage_en[k]=1 for k>=1, stage_flush[1]=1 only.
REQ-027 DRAIN or ~ihit: pc_en=0, stage_en all 1, stage_flush[0]=1 only; downstream registers keep advancing (bubble into reg 0).
REQ-028 Normal: pc_en=1, stage_en all 1, stage_flush=0.
REQ-029 stage_flush[k]=1 SHALL only be driven while stage_en[k]=1; flush wins over data.
REQ-030 valid update on the clock edge, when stage_en[k]=1: valid[k] <= 0 if stage_flush[k], else 1 for k=0, else valid[k-1]. When stage_en[k]=0, valid[k] holds.
REQ-031 FSM transitions:
- RUN -> DRAIN when halt_dec & valid[0] & ~redirect & ~mem_wait.
- DRAIN -> RUN when redirect & ~mem_wait (the halt was wrong-path and is squashed).
- DRAIN or RUN -> HALTED when halt_wb & valid[STAGES-1] & ~mem_wait.
- HALTED is terminal until reset.
REQ-032 halt SHALL be 1 whenever state=HALTED, taking effect the cycle after the transition.
REQ-033 Wait counter, 16 bits:
- increments each mem_wait cycle, clears on any cycle without mem_wait, saturates at WAIT_LIMIT.
- mem_timeout sets when the counter equals WAIT_LIMIT and stays 1 until reset.
- stalling is unaffected by mem_timeout.
REQ-034 stall_cycles increments by 1 on every cycle with state!=HALTED and pc_en=0; wraps from 2^32-1 to 0.
REQ-035 Simultaneous halt_wb and redirect in RUN: HALTED wins, because the halt is older.

Reset
REQ-036 While nRST=1: state=RUN, valid=0, halt=0, mem_timeout=0, wait counter=0, stall_cycles=0, asynchronously. Combinational outputs follow REQ-028 (pc_en=1, stage_en all 1, stage_flush=0).
REQ-037 Reset asserted mid-stall or mid-DRAIN SHALL discard all state; the first cycle after release is RUN with valid=0.

Verification
REQ-038 Reset release, ihit=1 for 4 cycles -> valid steps 0001, 0011, 0111, 1111; stall_cycles=0.
REQ-039 valid=1111, mem_req=1, dhit=0 for 3 cycles then 1 -> stage_en=0000 and pc_en=0 for 3 cycles; valid stays 1111; stall_cycles=3; wait counter back to 0.
REQ-040 load_use=1 for one cycle with valid=1111 -> stage_en=1110, stage_flush=0010; next cycle valid[1]=0, valid[0]=1.
REQ-041 redirect=1 with valid=1111 -> stage_flush=0111, pc_en=1; next cycle valid=1000.
REQ-042 halt_dec in RUN -> DRAIN with bubbles into reg 0; halt_wb 3 cycles later -> HALTED, halt=1, stage_en=0000 held for 10 cycles.
REQ-043 WAIT_LIMIT=4, dhit=0 with mem_req pending for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after dhit returns.
